// File: rtl/wb_sequencer_if.sv
// Writeback request / register-file port bundle for wb_sequencer.
// master = control unit side, slave = sequencer side.
interface wb_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src;
  logic [4:0] req_dst;
  logic       md_busy;
  logic [3:0] toreg_sel;
  logic [4:0] reg_dst;
  logic       reg_write;
  logic       wb_done;
  logic       wb_err;

  modport master (
    output req_valid, req_src, req_dst, md_busy,
    input  req_ready, toreg_sel, reg_dst, reg_write, wb_done, wb_err
  );

  modport slave (
    input  req_valid, req_src, req_dst, md_busy,
    output req_ready, toreg_sel, reg_dst, reg_write, wb_done, wb_err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Register-file writeback sequencer: one request at a time, stalled until its source is valid.
// Optional macro WB_ZERO_GUARD_EN suppresses the register write when the destination is r0.
module wb_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int SP_REG  = 29
) (
  input logic            clk,
  input logic            reset,
  wb_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_MEM,
    WAIT_MD,
    WRITE
  } state_t;

  localparam logic [3:0] SRC_ALU   = 4'd0;
  localparam logic [3:0] SRC_MDR   = 4'd1;
  localparam logic [3:0] SRC_HI    = 4'd2;
  localparam logic [3:0] SRC_LO    = 4'd3;
  localparam logic [3:0] SRC_C227  = 4'd4;
  localparam logic [3:0] SRC_C0    = 4'd5;
  localparam logic [3:0] SRC_C1    = 4'd6;
  localparam logic [3:0] SRC_SHIFT = 4'd7;
  localparam logic [3:0] SRC_OFFS  = 4'd8;

  state_t     state, state_nxt;
  logic [3:0] src_q, src_nxt;
  logic [4:0] dst_q, dst_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic       err_q, err_nxt;
  logic       write_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      src_q <= 4'd0;
      dst_q <= 5'd0;
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
      dst_q <= dst_nxt;
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Illegal sources are not latched, so toreg_sel can never exceed 8.
  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_src)
            SRC_ALU, SRC_C227, SRC_C0, SRC_C1, SRC_SHIFT, SRC_OFFS: begin
              src_nxt   = bus.req_src;
              dst_nxt   = bus.req_dst;
              state_nxt = WRITE;
            end
            SRC_MDR: begin
              src_nxt   = bus.req_src;
              dst_nxt   = bus.req_dst;
              cnt_nxt   = 4'(MEM_LAT - 1);
              state_nxt = WAIT_MEM;
            end
            SRC_HI, SRC_LO: begin
              src_nxt   = bus.req_src;
              dst_nxt   = bus.req_dst;
              state_nxt = bus.md_busy ? WAIT_MD : WRITE;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        if (cnt_q == 4'd0) begin
          state_nxt = WRITE;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      WAIT_MD: begin
        if (!bus.md_busy) begin
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

`ifdef WB_ZERO_GUARD_EN
  assign write_en = (dst_q != 5'd0);
`else
  assign write_en = 1'b1;
`endif

  // Outputs are gated while reset is held so nothing leaks from the INIT state early.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.toreg_sel = 4'd0;
    bus.reg_dst   = 5'd0;
    bus.reg_write = 1'b0;
    bus.wb_done   = 1'b0;
    bus.wb_err    = 1'b0;
    if (!reset) begin
      bus.toreg_sel = src_q;
      bus.reg_dst   = dst_q;
      case (state)
        INIT: begin
          bus.toreg_sel = SRC_C227;
          bus.reg_dst   = 5'(SP_REG);
          bus.reg_write = 1'b1;
        end
        IDLE: begin
          bus.req_ready = 1'b1;
          bus.wb_err    = err_q;
        end
        WRITE: begin
          bus.reg_write = write_en;
          bus.wb_done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed plan items followed by randomized requests
// checked against a per-request latency model.
module tb_wb_sequencer;
  localparam int MEM_LAT = 2;
  localparam int SP_REG  = 29;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] last_sel = 4'd0;
  logic [4:0] last_dst = 5'd0;

  wb_sequencer_if bus();

  wb_sequencer #(.MEM_LAT(MEM_LAT), .SP_REG(SP_REG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ready, input logic [3:0] sel,
                          input logic [4:0] dst, input logic wr, input logic done,
                          input logic err);
    checkOutput($sformatf("%s.req_ready", tag), 8'(bus.req_ready), 8'(ready));
    checkOutput($sformatf("%s.toreg_sel", tag), 8'(bus.toreg_sel), 8'(sel));
    checkOutput($sformatf("%s.reg_dst", tag),   8'(bus.reg_dst),   8'(dst));
    checkOutput($sformatf("%s.reg_write", tag), 8'(bus.reg_write), 8'(wr));
    checkOutput($sformatf("%s.wb_done", tag),   8'(bus.wb_done),   8'(done));
    checkOutput($sformatf("%s.wb_err", tag),    8'(bus.wb_err),    8'(err));
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] src,
                               input logic [4:0] dst, input logic busy);
    bus.req_valid = valid;
    bus.req_src   = src;
    bus.req_dst   = dst;
    bus.md_busy   = busy;
  endtask

  function automatic logic expWrite(input logic [4:0] dst);
`ifdef WB_ZERO_GUARD_EN
    return dst != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Cycles from acceptance to the WRITE cycle; busy = cycles md_busy stays high from acceptance.
  function automatic int writeDelay(input logic [3:0] src, input int busy);
    if (src == 4'd1) return 1 + MEM_LAT;
    if (src == 4'd2 || src == 4'd3) return busy + 1;
    return 1;
  endfunction

  task automatic doReset(input int cycles);
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 5'd0, 1'b0);
    #1;
    checkAll("reset", 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (i < cycles) checkAll("reset", 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    #1;
    checkAll("init", 1'b0, 4'd4, 5'(SP_REG), 1'b1, 1'b0, 1'b0);
    step();
    checkAll("post_init", 1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    last_sel = 4'd0;
    last_dst = 5'd0;
  endtask

  // Issues one request from IDLE and follows it back to IDLE; noisy drives junk requests while busy.
  task automatic runRequest(input logic [3:0] src, input logic [4:0] dst, input int busy,
                            input bit noisy);
    int d;
    checkOutput("idle.req_ready", 8'(bus.req_ready), 8'd1);
    applyStimulus(1'b1, src, dst, busy > 0);
    step();
    if (src > 4'd8) begin
      applyStimulus(1'b0, 4'd0, 5'd0, 1'b0);
      checkAll("illegal", 1'b1, last_sel, last_dst, 1'b0, 1'b0, 1'b1);
      return;
    end
    last_sel = src;
    last_dst = dst;
    d = writeDelay(src, busy);
    for (int c = 1; c < d; c++) begin
      applyStimulus(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom_range(0, 15)),
                    5'($urandom), c < busy);
      checkAll("wait", 1'b0, last_sel, last_dst, 1'b0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 4'd0, 5'd0, 1'b0);
    checkAll("write", 1'b0, src, dst, expWrite(dst), 1'b1, 1'b0);
    step();
  endtask

  initial begin
    logic [3:0] rsrc;
    logic [4:0] rdst;
    int         rbusy;

    applyStimulus(1'b0, 4'd0, 5'd0, 1'b0);
    doReset(3);

    runRequest(4'd0, 5'd8, 0, 1'b0);
    runRequest(4'd1, 5'd9, 0, 1'b0);
    runRequest(4'd2, 5'd10, 4, 1'b0);
    runRequest(4'hB, 5'd12, 0, 1'b0);
    runRequest(4'd6, 5'd0, 0, 1'b0);
    runRequest(4'd3, 5'd17, 0, 1'b0);
    runRequest(4'd8, 5'd31, 0, 1'b1);
    runRequest(4'd3, 5'd5, 1, 1'b1);

    // Reset while a Hi read is stalled on the mult/div unit.
    checkOutput("mdreset.req_ready", 8'(bus.req_ready), 8'd1);
    applyStimulus(1'b1, 4'd2, 5'd10, 1'b1);
    step();
    applyStimulus(1'b0, 4'd0, 5'd0, 1'b1);
    checkAll("mdreset.wait1", 1'b0, 4'd2, 5'd10, 1'b0, 1'b0, 1'b0);
    step();
    checkAll("mdreset.wait2", 1'b0, 4'd2, 5'd10, 1'b0, 1'b0, 1'b0);
    doReset(1);
    bus.md_busy = 1'b0;

    for (int n = 0; n < 60; n++) begin
      rsrc  = 4'($urandom_range(0, 15));
      rdst  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      rbusy = $urandom_range(0, 5);
      runRequest(rsrc, rdst, rbusy, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Register-file writeback sequencer for the multicycle datapath. It owns the 4-bit select of the writeback source mux, the destination register index and the register-file write enable. It accepts one writeback request at a time from the main control unit and stalls that request until its source is valid: memory data after a fixed latency, Hi/Lo once the mult/div unit is idle. After every reset it performs the mandatory stack-pointer initialisation write of constant 227.

## Interface
- `MEM_LAT`, 2: cycles from request acceptance until MDR data is valid; legal range 1..15.
- `SP_REG`, 29: register index written with 227 after reset.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: control unit presents a writeback request.
- `req_ready` out 1: high only in IDLE; a request is accepted on a cycle where `req_valid && req_ready`.
- `req_src` in 4: source code. 0 AluOut, 1 MDR, 2 Hi, 3 Lo, 4 const 227, 5 const 0, 6 const 1, 7 shift-register out, 8 offset<<16.
- `req_dst` in 5: destination register index.
- `md_busy` in 1: mult/div unit is still computing Hi/Lo.
- `toreg_sel` out 4: select to the writeback source mux.
- `reg_dst` out 5: register-file write address.
- `reg_write` out 1: register-file write enable.
- `wb_done` out 1: one-cycle pulse when a request finishes.
- `wb_err` out 1: one-cycle pulse when an illegal source code is rejected.

## Operation
- Moore FSM with states INIT, IDLE, WAIT_MEM, WAIT_MD, WRITE.
- The accepted `req_src` and `req_dst` are latched into internal registers. `toreg_sel` and `reg_dst` are driven from these registers in every state except INIT.
- **INIT**
  - Entered on reset.
  - Drives `toreg_sel=4'd4`, `reg_dst=SP_REG`, `reg_write=1`.
  - Goes to IDLE after one cycle.
- **IDLE**
  - Drives `req_ready=1`.
  - On acceptance, the next state depends on `req_src`:
    - src 0 or 4..8: go to WRITE.
    - src 1: go to WAIT_MEM; a counter is loaded with MEM_LAT−1.
    - src 2 or 3: go to WRITE if `md_busy==0` in the accepting cycle, otherwise go to WAIT_MD.
    - src 9..15: no state change; `wb_err` pulses in the next cycle; no write occurs.
- **WAIT_MEM**
  - Counter decrements each cycle.
  - Go to WRITE on the cycle the counter is 0.
- **WAIT_MD**
  - Go to WRITE on the first cycle `md_busy==0` is sampled.
  - No timeout.
- **WRITE**
  - Drives `reg_write=1` and `wb_done=1`.
  - Returns to IDLE.
- `req_valid` while not in IDLE is ignored; the requester must hold it until `req_ready`.
- `toreg_sel` never carries a value above 8.

## Timing
- **During reset:** all outputs 0 and the latched request is cleared.
- **First cycle after reset deasserts:** INIT (SP write), with `req_ready=0`.
- **Second cycle after reset deasserts:** IDLE.
- **Latency**, with acceptance in cycle N:
  - src 0/4..8: WRITE in N+1.
  - src 1: WRITE in N+1+MEM_LAT.
  - src 2/3 with unit idle: WRITE in N+1.
  - src 2/3 with unit busy: WRITE in the cycle after the first sample of `md_busy==0`.
- **Throughput:** best case, one request every 2 cycles (IDLE, then WRITE).
- **Reset mid-operation** (any state): the pending request is discarded with no write or `wb_done` for it, and the FSM re-enters INIT, so the SP write repeats.
- **`md_busy` deasserts in the same cycle as a src 2/3 acceptance:** go directly to WRITE.
- **Illegal src:** `wb_err` pulses in cycle N+1; `req_ready` stays 1.

## Configuration
- Macro: `WB_ZERO_GUARD_EN`.
- **Defined:** in WRITE, when the latched dst is 0, `reg_write` is forced to 0. `wb_done` still pulses and timing is unchanged. The INIT write is unaffected.
- **Undefined:** `reg_write` is asserted in WRITE regardless of dst.

## Test plan
- **Reset release:** `reset` 1 for 3 cycles, then 0 → cycle 1 has `reg_write=1`, `toreg_sel=4`, `reg_dst=29`; cycle 2 has `req_ready=1`.
- **ALU writeback:** src=0, dst=8 accepted in cycle N → in N+1 `reg_write=1`, `toreg_sel=0`, `reg_dst=8`, `wb_done=1`; `req_ready=1` again in N+2.
- **MDR writeback:** src=1, dst=9, MEM_LAT=2, accepted in cycle N → no write in N+1 or N+2; `reg_write=1` with `toreg_sel=1` in N+3.
- **Hi read while busy:** src=2, dst=10, `md_busy` high until cycle N+4 → WRITE in N+5 with `toreg_sel=2`.
- **Illegal source:** src=4'hB → `wb_err=1` in N+1, `reg_write` stays 0, `req_ready` stays 1.
- **Zero guard and mid-wait reset:**
  - src=6, dst=0 → `reg_write=0` in WRITE when `WB_ZERO_GUARD_EN` is defined, 1 when undefined; `wb_done=1` either way.
  - `reset` pulse during WAIT_MD → no `wb_done`, and the INIT SP write repeats.
